// File: rtl/lsu.sv
// Byte-serial load/store unit between the LSB and the 8-bit memctrl port.
// Optional macro LSU_IO_STALL_EN: hold IO-space stores while the IO buffer is full.
module lsu #(
  parameter int         ADDR_W     = 32,
  parameter logic [1:0] IO_BASE_HI = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              en_signal_from_lsb,
  input  logic [5:0]        inst_name_from_lsb,
  input  logic [ADDR_W-1:0] mem_addr_from_lsb,
  input  logic [31:0]       store_value_from_lsb,
  input  logic [4:0]        rob_id_from_lsb,
  output logic              busy_to_lsb,
  output logic              valid_to_cdb,
  output logic [31:0]       result_to_cdb,
  output logic [4:0]        rob_id_to_cdb,
  output logic              mem_req_to_memctrl,
  input  logic              mem_grant_from_memctrl,
  output logic [ADDR_W-1:0] mem_addr_to_memctrl,
  output logic              mem_wr_to_memctrl,
  output logic [7:0]        mem_dout_to_memctrl,
  input  logic [7:0]        mem_din_from_memctrl,
  input  logic              io_buffer_full_from_memctrl,
  input  logic              rollback_flag_from_rob
);

  localparam logic [5:0] INST_LB  = 6'd11;
  localparam logic [5:0] INST_LH  = 6'd12;
  localparam logic [5:0] INST_LW  = 6'd13;
  localparam logic [5:0] INST_LBU = 6'd14;
  localparam logic [5:0] INST_LHU = 6'd15;
  localparam logic [5:0] INST_SB  = 6'd16;
  localparam logic [5:0] INST_SH  = 6'd17;
  localparam logic [5:0] INST_SW  = 6'd18;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [5:0]        name_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       val_q;
  logic [31:0]       data_q;
  logic [4:0]        rob_q;
  logic [2:0]        size_q;
  logic [2:0]        issue_cnt;
  logic [2:0]        recv_cnt;
  logic              st_q;
  logic              pend_q;

  logic       st_in;
  logic [2:0] size_in;
  logic       accept;
  logic       abort;
  logic       done_hit;
  logic       io_stall;
  logic       issue;
  logic [31:0] val_sh;

  // decode size and direction of the incoming request
  always_comb begin
    st_in   = 1'b0;
    size_in = 3'd4;
    unique case (1'b1)
      (inst_name_from_lsb == INST_SB): begin
        st_in   = 1'b1;
        size_in = 3'd1;
      end
      (inst_name_from_lsb == INST_SH): begin
        st_in   = 1'b1;
        size_in = 3'd2;
      end
      (inst_name_from_lsb == INST_SW): begin
        st_in   = 1'b1;
        size_in = 3'd4;
      end
      (inst_name_from_lsb == INST_LB),
      (inst_name_from_lsb == INST_LBU): size_in = 3'd1;
      (inst_name_from_lsb == INST_LH),
      (inst_name_from_lsb == INST_LHU): size_in = 3'd2;
      default: size_in = 3'd4;
    endcase
  end

`ifdef LSU_IO_STALL_EN
  assign io_stall = st_q
                  && (addr_q[17:16] == IO_BASE_HI)
                  && io_buffer_full_from_memctrl;
`else
  logic unused_io;
  assign unused_io = io_buffer_full_from_memctrl;
  assign io_stall  = 1'b0;
`endif

  // a flushed load never enters; stores are already committed
  assign accept = rdy_in
                && (state_q != S_ACCESS)
                && en_signal_from_lsb
                && !(rollback_flag_from_rob && !st_in);

  assign abort    = rollback_flag_from_rob && !st_q;
  assign done_hit = st_q ? (issue_cnt == size_q)
                         : (recv_cnt == size_q);

  assign busy_to_lsb = (state_q == S_ACCESS);

  assign mem_req_to_memctrl = rdy_in
                            && (state_q == S_ACCESS)
                            && (issue_cnt < size_q)
                            && !io_stall;

  assign issue  = mem_req_to_memctrl && mem_grant_from_memctrl;
  assign val_sh = val_q >> {issue_cnt[1:0], 3'b000};

  assign mem_addr_to_memctrl = mem_req_to_memctrl
                             ? addr_q + ADDR_W'(issue_cnt)
                             : '0;
  assign mem_wr_to_memctrl   = mem_req_to_memctrl && st_q;
  assign mem_dout_to_memctrl = mem_wr_to_memctrl ? val_sh[7:0] : 8'h00;

  // completion pulse and extended load result
  always_comb begin
    valid_to_cdb  = rdy_in && (state_q == S_DONE) && !abort;
    result_to_cdb = 32'h0;
    rob_id_to_cdb = 5'h0;
    if (valid_to_cdb) begin
      rob_id_to_cdb = rob_q;
      unique case (1'b1)
        st_q: result_to_cdb = 32'h0;
        (name_q == INST_LB):
          result_to_cdb = {{24{data_q[7]}}, data_q[7:0]};
        (name_q == INST_LH):
          result_to_cdb = {{16{data_q[15]}}, data_q[15:0]};
        (name_q == INST_LBU):
          result_to_cdb = {24'h0, data_q[7:0]};
        (name_q == INST_LHU):
          result_to_cdb = {16'h0, data_q[15:0]};
        default: result_to_cdb = data_q;
      endcase
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_ACCESS;
      S_ACCESS: begin
        if (abort)         state_d = S_IDLE;
        else if (done_hit) state_d = S_DONE;
      end
      S_DONE:   state_d = accept ? S_ACCESS : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_in) begin
    if (rst_in)      state_q <= S_IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  // request latch, byte counters and load assembly
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      name_q    <= '0;
      addr_q    <= '0;
      val_q     <= '0;
      rob_q     <= '0;
      size_q    <= '0;
      st_q      <= 1'b0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      data_q    <= '0;
      pend_q    <= 1'b0;
    end else if (rdy_in) begin
      if (accept) begin
        name_q    <= inst_name_from_lsb;
        addr_q    <= mem_addr_from_lsb;
        val_q     <= store_value_from_lsb;
        rob_q     <= rob_id_from_lsb;
        size_q    <= size_in;
        st_q      <= st_in;
        issue_cnt <= '0;
        recv_cnt  <= '0;
        data_q    <= '0;
        pend_q    <= 1'b0;
      end else if (state_q == S_ACCESS) begin
        if (issue) issue_cnt <= issue_cnt + 3'd1;
        pend_q <= issue && !st_q && !abort;
        if (pend_q && !abort) begin
          data_q[{recv_cnt[1:0], 3'b000} +: 8] <= mem_din_from_memctrl;
          recv_cnt <= recv_cnt + 3'd1;
        end
      end else begin
        pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu.
// Memory model and write log live here.
module tb_lsu;

  localparam logic [5:0] LB  = 6'd11;
  localparam logic [5:0] LH  = 6'd12;
  localparam logic [5:0] LW  = 6'd13;
  localparam logic [5:0] LBU = 6'd14;
  localparam logic [5:0] LHU = 6'd15;
  localparam logic [5:0] SB  = 6'd16;
  localparam logic [5:0] SH  = 6'd17;
  localparam logic [5:0] SW  = 6'd18;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        en = 1'b0;
  logic [5:0]  name = '0;
  logic [31:0] addr = '0;
  logic [31:0] sval = '0;
  logic [4:0]  rob = '0;
  logic        busy, valid;
  logic [31:0] result;
  logic [4:0]  rob_out;
  logic        req;
  logic        gnt = 1'b1;
  logic [31:0] maddr;
  logic        wr;
  logic [7:0]  dout;
  logic [7:0]  din = 8'h00;
  logic        io_full = 1'b0;
  logic        rb = 1'b0;

  logic [7:0]  mem [0:4095];
  logic [39:0] wlog [$];

  int errors = 0;
  int checks = 0;
  int lat;
  logic got;
  int vcnt;

  always #5 clk_in = ~clk_in;

  lsu dut (
    .clk_in                      (clk_in),
    .rst_in                      (rst_in),
    .rdy_in                      (rdy_in),
    .en_signal_from_lsb          (en),
    .inst_name_from_lsb          (name),
    .mem_addr_from_lsb           (addr),
    .store_value_from_lsb        (sval),
    .rob_id_from_lsb             (rob),
    .busy_to_lsb                 (busy),
    .valid_to_cdb                (valid),
    .result_to_cdb               (result),
    .rob_id_to_cdb               (rob_out),
    .mem_req_to_memctrl          (req),
    .mem_grant_from_memctrl      (gnt),
    .mem_addr_to_memctrl         (maddr),
    .mem_wr_to_memctrl           (wr),
    .mem_dout_to_memctrl         (dout),
    .mem_din_from_memctrl        (din),
    .io_buffer_full_from_memctrl (io_full),
    .rollback_flag_from_rob      (rb)
  );

  always @(posedge clk_in) begin
    if (req && gnt) begin
      if (wr) begin
        mem[maddr[11:0]] <= dout;
        wlog.push_back({maddr, dout});
      end else begin
        din <= mem[maddr[11:0]];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [5:0] n, input logic [31:0] a,
                      input logic [31:0] v, input logic [4:0] r);
    en = 1'b1; name = n; addr = a; sval = v; rob = r;
    @(posedge clk_in); #1;
    en = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output int l, output logic g);
    g = 1'b0;
    l = 0;
    for (int i = 0; i < maxc && !g; i++) begin
      @(posedge clk_in); #1;
      l++;
      if (valid) g = 1'b1;
    end
  endtask

  task automatic idle1();
    @(posedge clk_in); #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h78; mem[12'h101] = 8'h56;
    mem[12'h102] = 8'h34; mem[12'h103] = 8'h12;
    mem[12'h200] = 8'h80;
    mem[12'h300] = 8'hAA; mem[12'h301] = 8'hBB;
    mem[12'h302] = 8'hCC; mem[12'h303] = 8'hDD;
    mem[12'h400] = 8'h01; mem[12'h401] = 8'h80;

    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_rob", {27'h0, rob_out}, 32'h0);
    chk("rst_addr", maddr, 32'h0);
    chk("rst_wr", {31'h0, wr}, 32'h0);
    rst_in = 1'b0;
    idle1();

    send(LW, 32'h100, 32'h0, 5'd7);
    chk("lw_busy", {31'h0, busy}, 32'h1);
    wait_valid(20, lat, got);
    chk("lw_valid", {31'h0, got}, 32'h1);
    chk("lw_lat", lat, 32'd6);
    chk("lw_res", result, 32'h12345678);
    chk("lw_rob", {27'h0, rob_out}, 32'd7);
    idle1();
    chk("lw_pulse", {31'h0, valid}, 32'h0);

    send(LB, 32'h200, 32'h0, 5'd3);
    wait_valid(20, lat, got);
    chk("lb_valid", {31'h0, got}, 32'h1);
    chk("lb_lat", lat, 32'd3);
    chk("lb_res", result, 32'hFFFFFF80);
    chk("lb_busy_done", {31'h0, busy}, 32'h0);
    send(LBU, 32'h200, 32'h0, 5'd4);
    chk("lbu_b2b_busy", {31'h0, busy}, 32'h1);
    wait_valid(20, lat, got);
    chk("lbu_lat", lat, 32'd3);
    chk("lbu_res", result, 32'h00000080);
    chk("lbu_rob", {27'h0, rob_out}, 32'd4);
    idle1();

    send(LH, 32'h400, 32'h0, 5'd5);
    wait_valid(20, lat, got);
    chk("lh_lat", lat, 32'd4);
    chk("lh_res", result, 32'hFFFF8001);
    idle1();
    send(LHU, 32'h400, 32'h0, 5'd6);
    wait_valid(20, lat, got);
    chk("lhu_res", result, 32'h00008001);
    idle1();

    wlog.delete();
    send(SB, 32'h50, 32'h0000005A, 5'd8);
    wait_valid(20, lat, got);
    chk("sb_lat", lat, 32'd2);
    chk("sb_res", result, 32'h0);
    chk("sb_mem", {24'h0, mem[12'h050]}, 32'h5A);
    idle1();

    send(SW, 32'h60, 32'h11223344, 5'd9);
    wait_valid(20, lat, got);
    chk("sw_lat", lat, 32'd5);
    chk("sw_mem", {mem[12'h063], mem[12'h062], mem[12'h061], mem[12'h060]},
        32'h11223344);
    idle1();

    wlog.delete();
    send(SH, 32'h1FF, 32'h0000ABCD, 5'd10);
    chk("sh_a0", maddr, 32'h1FF);
    chk("sh_d0", {24'h0, dout}, 32'hCD);
    idle1();
    gnt = 1'b0;
    chk("sh_stall_addr", maddr, 32'h200);
    idle1();
    gnt = 1'b1;
    chk("sh_a1", maddr, 32'h200);
    chk("sh_d1", {24'h0, dout}, 32'hAB);
    wait_valid(20, lat, got);
    chk("sh_valid", {31'h0, got}, 32'h1);
    chk("sh_lat", lat, 32'd2);
    chk("sh_nwr", wlog.size(), 32'd2);
    if (wlog.size() == 2) begin
      chk("sh_w0", wlog[0], {32'h1FF, 8'hCD});
      chk("sh_w1", wlog[1], {32'h200, 8'hAB});
    end
    idle1();

    send(LW, 32'h300, 32'h0, 5'd11);
    idle1();
    rb = 1'b1;
    chk("rb_lw_v", {31'h0, valid}, 32'h0);
    idle1();
    rb = 1'b0;
    chk("rb_lw_busy", {31'h0, busy}, 32'h0);
    chk("rb_lw_req", {31'h0, req}, 32'h0);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (valid) vcnt++;
      idle1();
    end
    chk("rb_lw_novalid", vcnt, 32'd0);

    wlog.delete();
    send(SW, 32'h340, 32'hDEADBEEF, 5'd12);
    idle1();
    rb = 1'b1;
    idle1();
    rb = 1'b0;
    wait_valid(20, lat, got);
    chk("rb_sw_valid", {31'h0, got}, 32'h1);
    chk("rb_sw_rob", {27'h0, rob_out}, 32'd12);
    chk("rb_sw_mem", {mem[12'h343], mem[12'h342], mem[12'h341], mem[12'h340]},
        32'hDEADBEEF);
    chk("rb_sw_nwr", wlog.size(), 32'd4);
    idle1();

    en = 1'b1; name = LW; addr = 32'h100; rob = 5'd13; rb = 1'b1;
    idle1();
    en = 1'b0; rb = 1'b0;
    chk("rb_idle_ld", {31'h0, busy}, 32'h0);
    en = 1'b1; name = SB; addr = 32'h70; sval = 32'h33; rob = 5'd14;
    rb = 1'b1;
    idle1();
    en = 1'b0; rb = 1'b0;
    chk("rb_idle_st", {31'h0, busy}, 32'h1);
    wait_valid(20, lat, got);
    chk("rb_idle_st_v", {31'h0, got}, 32'h1);
    chk("rb_idle_st_m", {24'h0, mem[12'h070]}, 32'h33);
    idle1();

    wlog.delete();
    io_full = 1'b1;
    send(SB, 32'h30000, 32'h99, 5'd15);
`ifdef LSU_IO_STALL_EN
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (req) vcnt++;
      idle1();
    end
    chk("io_stall_req", vcnt, 32'd0);
    chk("io_stall_nwr", wlog.size(), 32'd0);
    io_full = 1'b0;
    chk("io_go_req", {31'h0, req}, 32'h1);
    chk("io_go_addr", maddr, 32'h30000);
    wait_valid(20, lat, got);
`else
    chk("io_req", {31'h0, req}, 32'h1);
    chk("io_addr", maddr, 32'h30000);
    wait_valid(20, lat, got);
    chk("io_lat", lat, 32'd2);
`endif
    io_full = 1'b0;
    chk("io_valid", {31'h0, got}, 32'h1);
    chk("io_nwr", wlog.size(), 32'd1);
    if (wlog.size() == 1) chk("io_w", wlog[0], {32'h30000, 8'h99});
    idle1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
